// File: rtl/bc_pkg.sv
// bc_pkg: shared state encoding, constants and helpers for the Bulls & Cows
// game engine (bc_game_engine and bc_digit_match).
package bc_pkg;

  typedef enum logic [3:0] {
    P1_SETUP = 4'd0,
    P2_SETUP = 4'd1,
    P1_GUESS = 4'd2,
    P2_GUESS = 4'd3,
    VALIDATE = 4'd4,
    SCORE    = 4'd5,
    RESULT   = 4'd6,
    WIN      = 4'd7,
    DRAW     = 4'd8
  } bc_state_t;

  // Largest digit value accepted when decimal-only entry is enabled.
  localparam int BC_MAX_DECIMAL = 9;

  // Width of a counter that holds 0..n_digits without wrapping.
  function automatic int bc_score_w(input int n_digits);
    return $clog2(n_digits + 1);
  endfunction

endpackage

// File: rtl/bc_digit_match.sv
// bc_digit_match: compares one digit against every digit of a packed vector.
// pos_hit flags a match at the given position, other_hit a match anywhere
// else. Used both for entry uniqueness and for bull/cow scoring.
module bc_digit_match
  import bc_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int IDX_W      = 2
) (
  input  logic [DIGIT_W-1:0]            i_digit,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] i_vec,
  input  logic [IDX_W-1:0]              i_pos,
  output logic                          o_pos_hit,
  output logic                          o_other_hit
);

  // Scan every position of the vector for the candidate digit.
  always_comb begin
    o_pos_hit   = 1'b0;
    o_other_hit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (i_vec[k*DIGIT_W +: DIGIT_W] == i_digit) begin
        if (k == int'(i_pos)) o_pos_hit = 1'b1;
        else                  o_other_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bc_game_engine.sv
// bc_game_engine: two-player Bulls & Cows engine. Entries are validated one
// digit per cycle, guesses are scored one digit per cycle, rounds are counted
// up to a draw limit and the winner is reported.
// Optional build macro: BC_DECIMAL_ONLY_EN -- when defined, any entry digit
// greater than 9 is rejected during validation.
module bc_game_engine
  import bc_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_ROUNDS = 10
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  confirma,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]         sw,
  output logic [3:0]                            state_o,
  output logic                                  player_o,
  output logic [bc_score_w(NUM_DIGITS)-1:0]     bulls_o,
  output logic [bc_score_w(NUM_DIGITS)-1:0]     cows_o,
  output logic [7:0]                            round_o,
  output logic                                  err_o,
  output logic                                  winner_o,
  output logic                                  busy_o
);

  localparam int ENTRY_W = NUM_DIGITS * DIGIT_W;
  localparam int SCORE_W = bc_score_w(NUM_DIGITS);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'(NUM_DIGITS);
  localparam logic [7:0]         LAST_ROUND = 8'(MAX_ROUNDS);

  // Control state
  bc_state_t            r_state;
  bc_state_t            w_state_nxt;
  bc_state_t            r_ret;
  logic                 r_conf_q;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_fail;

  // Game data
  logic [ENTRY_W-1:0]   r_entry;
  logic [ENTRY_W-1:0]   r_secret1;
  logic [ENTRY_W-1:0]   r_secret2;
  logic [SCORE_W-1:0]   r_bulls;
  logic [SCORE_W-1:0]   r_cows;
  logic [7:0]           r_round;
  logic                 r_err;
  logic                 r_winner;
  logic                 r_player;

  // Combinational helpers
  logic                 w_edge;
  logic                 w_entry_state;
  logic                 w_last;
  logic [DIGIT_W-1:0]   w_digit;
  logic [ENTRY_W-1:0]   w_vec;
  logic                 w_pos_hit;
  logic                 w_other_hit;
  logic                 w_dec_bad;
  logic                 w_val_fail;

  assign w_edge        = confirma & ~r_conf_q;
  assign w_entry_state = (r_state == P1_SETUP) || (r_state == P2_SETUP) ||
                         (r_state == P1_GUESS) || (r_state == P2_GUESS);
  assign w_last        = (r_idx == LAST_IDX);

  // During SCORE the captured guess is compared against the opponent's secret;
  // during VALIDATE the entry is compared against itself.
  assign w_vec = (r_state == SCORE) ? (r_player ? r_secret1 : r_secret2) : r_entry;

  // Select the entry digit addressed by the serial index.
  always_comb begin
    w_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_digit = r_entry[k*DIGIT_W +: DIGIT_W];
    end
  end

  bc_digit_match #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .IDX_W      (IDX_W)
  ) u_match (
    .i_digit     (w_digit),
    .i_vec       (w_vec),
    .i_pos       (r_idx),
    .o_pos_hit   (w_pos_hit),
    .o_other_hit (w_other_hit)
  );

`ifdef BC_DECIMAL_ONLY_EN
  assign w_dec_bad = (32'(w_digit) > 32'(BC_MAX_DECIMAL));
`else
  assign w_dec_bad = 1'b0;
`endif

  // A repeated digit shows up as a hit at some other position of the entry.
  assign w_val_fail = r_fail | w_other_hit | w_dec_bad;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= P1_SETUP;
    else          r_state <= w_state_nxt;
  end

  // Next-state decision for the game flow.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      P1_SETUP, P2_SETUP, P1_GUESS, P2_GUESS: begin
        if (w_edge) w_state_nxt = VALIDATE;
      end
      VALIDATE: begin
        if (w_last) begin
          if (w_val_fail) begin
            w_state_nxt = r_ret;
          end else begin
            case (r_ret)
              P1_SETUP: w_state_nxt = P2_SETUP;
              P2_SETUP: w_state_nxt = P1_GUESS;
              default:  w_state_nxt = SCORE;
            endcase
          end
        end
      end
      SCORE: begin
        if (w_last) w_state_nxt = RESULT;
      end
      RESULT: begin
        if (w_edge) begin
          if (r_bulls == FULL_SCORE)    w_state_nxt = WIN;
          else if (!r_player)           w_state_nxt = P2_GUESS;
          else if (r_round == LAST_ROUND) w_state_nxt = DRAW;
          else                          w_state_nxt = P1_GUESS;
        end
      end
      WIN, DRAW: begin
        if (w_edge) w_state_nxt = P1_SETUP;
      end
      default: w_state_nxt = P1_SETUP;
    endcase
  end

  // Entry capture on a confirm edge; sw changes afterwards are ignored.
  always_ff @(posedge clock) begin
    if (w_entry_state && w_edge) r_entry <= sw;
  end

  // Game bookkeeping: validation progress, secrets, scores, rounds, winner.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_conf_q  <= 1'b1;
      r_ret     <= P1_SETUP;
      r_idx     <= '0;
      r_fail    <= 1'b0;
      r_secret1 <= '0;
      r_secret2 <= '0;
      r_bulls   <= '0;
      r_cows    <= '0;
      r_round   <= '0;
      r_err     <= 1'b0;
      r_winner  <= 1'b0;
      r_player  <= 1'b0;
    end else begin
      r_conf_q <= confirma;
      case (r_state)
        P1_SETUP, P2_SETUP, P1_GUESS, P2_GUESS: begin
          if (w_edge) begin
            r_ret  <= r_state;
            r_err  <= 1'b0;
            r_idx  <= '0;
            r_fail <= 1'b0;
          end
        end
        VALIDATE: begin
          r_fail <= w_val_fail;
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end else begin
            r_idx <= '0;
            if (w_val_fail) begin
              r_err <= 1'b1;
            end else begin
              case (r_ret)
                P1_SETUP: begin
                  r_secret1 <= r_entry;
                  r_player  <= 1'b1;
                end
                P2_SETUP: begin
                  r_secret2 <= r_entry;
                  r_player  <= 1'b0;
                  r_round   <= 8'd1;
                end
                default: begin
                  r_bulls <= '0;
                  r_cows  <= '0;
                end
              endcase
            end
          end
        end
        SCORE: begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_pos_hit)        r_bulls <= r_bulls + SCORE_W'(1);
          else if (w_other_hit) r_cows  <= r_cows + SCORE_W'(1);
        end
        RESULT: begin
          if (w_edge) begin
            if (r_bulls == FULL_SCORE) begin
              r_winner <= r_player;
            end else if (!r_player) begin
              r_player <= 1'b1;
            end else if (r_round < LAST_ROUND) begin
              r_round  <= r_round + 8'd1;
              r_player <= 1'b0;
            end
          end
        end
        WIN, DRAW: begin
          if (w_edge) begin
            r_secret1 <= '0;
            r_secret2 <= '0;
            r_bulls   <= '0;
            r_cows    <= '0;
            r_round   <= '0;
            r_err     <= 1'b0;
            r_winner  <= 1'b0;
            r_player  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o  = r_state;
  assign player_o = r_player;
  assign bulls_o  = r_bulls;
  assign cows_o   = r_cows;
  assign round_o  = r_round;
  assign err_o    = r_err;
  assign winner_o = r_winner;
  assign busy_o   = (r_state == VALIDATE) || (r_state == SCORE);

endmodule

// File: tb/tb_bc_game_engine.sv
// tb_bc_game_engine: scoreboard bench for bc_game_engine. Stimulus pushes the
// expected outcome of every button press into a queue; a monitor compares the
// DUT whenever it settles in a new non-busy state.
module tb_bc_game_engine;
  import bc_pkg::*;

  localparam int ND  = 4;
  localparam int DW  = 4;
  localparam int MR  = 2;
  localparam int SW  = ND * DW;
  localparam int SCW = $clog2(ND + 1);

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           confirma = 1'b1;
  logic [SW-1:0]  sw = '0;
  logic [3:0]     state_o;
  logic           player_o;
  logic [SCW-1:0] bulls_o;
  logic [SCW-1:0] cows_o;
  logic [7:0]     round_o;
  logic           err_o;
  logic           winner_o;
  logic           busy_o;

  bc_game_engine #(
    .NUM_DIGITS (ND),
    .DIGIT_W    (DW),
    .MAX_ROUNDS (MR)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .confirma (confirma),
    .sw       (sw),
    .state_o  (state_o),
    .player_o (player_o),
    .bulls_o  (bulls_o),
    .cows_o   (cows_o),
    .round_o  (round_o),
    .err_o    (err_o),
    .winner_o (winner_o),
    .busy_o   (busy_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bc_state_t st;
    logic      pl;
    int        bulls;
    int        cows;
    int        round;
    logic      err;
    logic      win;
    int        lat;
    int        t0;
  } exp_t;

  exp_t expq[$];
  exp_t snapq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference game model
  bc_state_t     m_st;
  logic          m_pl;
  int            m_bulls, m_cows, m_round;
  logic          m_err, m_win;
  logic [SW-1:0] m_sec1, m_sec2;

  function automatic int dig(input logic [SW-1:0] v, input int k);
    return int'(v[k*DW +: DW]);
  endfunction

  function automatic logic legal(input logic [SW-1:0] v);
    for (int i = 0; i < ND; i++)
      for (int j = i + 1; j < ND; j++)
        if (dig(v, i) == dig(v, j)) return 1'b0;
`ifdef BC_DECIMAL_ONLY_EN
    for (int i = 0; i < ND; i++)
      if (dig(v, i) > 9) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [SW-1:0] rand_entry();
    logic [SW-1:0] v;
    logic [15:0]   used;
    int            d;
    if ($urandom_range(0, 3) == 0) return SW'($urandom);
    v = '0;
    used = '0;
    for (int k = 0; k < ND; k++) begin
      do d = $urandom_range(0, (1 << DW) - 1); while (used[d]);
      used[d] = 1'b1;
      v[k*DW +: DW] = DW'(d);
    end
    return v;
  endfunction

  task automatic m_reset();
    m_st = P1_SETUP; m_pl = 1'b0; m_bulls = 0; m_cows = 0; m_round = 0;
    m_err = 1'b0; m_win = 1'b0; m_sec1 = '0; m_sec2 = '0;
  endtask

  function automatic exp_t snap_model(input int lat);
    exp_t e;
    e.st = m_st; e.pl = m_pl; e.bulls = m_bulls; e.cows = m_cows;
    e.round = m_round; e.err = m_err; e.win = m_win; e.lat = lat; e.t0 = cyc;
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e, input logic with_lat);
    chk({tag, ".state"},  int'(state_o),  int'(e.st));
    chk({tag, ".player"}, int'(player_o), int'(e.pl));
    chk({tag, ".bulls"},  int'(bulls_o),  e.bulls);
    chk({tag, ".cows"},   int'(cows_o),   e.cows);
    chk({tag, ".round"},  int'(round_o),  e.round);
    chk({tag, ".err"},    int'(err_o),    int'(e.err));
    chk({tag, ".winner"}, int'(winner_o), int'(e.win));
    chk({tag, ".busy"},   int'(busy_o),   0);
    if (with_lat) chk({tag, ".latency"}, cyc - e.t0, e.lat);
  endtask

  // Monitor: compares on every settle into a non-busy state and on snapshots.
  logic [3:0] prev_st = 4'd0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      prev_st = state_o;
    end else begin
      while (snapq.size() > 0) begin
        e = snapq.pop_front();
        check_all("snap", e, 1'b0);
      end
      if (state_o != prev_st && state_o != 4'(VALIDATE) && state_o != 4'(SCORE)) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_transition: got state %0d, required no transition", state_o);
        end else begin
          e = expq.pop_front();
          check_all("trans", e, 1'b1);
        end
      end else if (expq.size() > 0 && (cyc - expq[0].t0) > 40) begin
        e = expq.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL timeout: got no settle after %0d cycles, required state %0d", cyc - e.t0, int'(e.st));
      end
      prev_st = state_o;
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while ((expq.size() != 0 || snapq.size() != 0) && n < 200);
    if (n >= 200) begin
      $display("FAIL wait_idle: got %0d pending items, required 0", expq.size() + snapq.size());
      $fatal(1);
    end
  endtask

  task automatic snapshot();
    snapq.push_back(snap_model(0));
    wait_idle();
  endtask

  // One confirm press with entry v; the model predicts the settled outcome.
  task automatic press(input logic [SW-1:0] v);
    int lat;
    logic [SW-1:0] tgt;
    logic hit;
    lat = 1;
    case (m_st)
      P1_SETUP, P2_SETUP, P1_GUESS, P2_GUESS: begin
        m_err = 1'b0;
        lat = ND + 1;
        if (!legal(v)) begin
          m_err = 1'b1;
        end else if (m_st == P1_SETUP) begin
          m_sec1 = v; m_st = P2_SETUP; m_pl = 1'b1;
        end else if (m_st == P2_SETUP) begin
          m_sec2 = v; m_st = P1_GUESS; m_pl = 1'b0; m_round = 1;
        end else begin
          tgt = m_pl ? m_sec1 : m_sec2;
          m_bulls = 0; m_cows = 0;
          for (int k = 0; k < ND; k++) begin
            if (dig(v, k) == dig(tgt, k)) begin
              m_bulls++;
            end else begin
              hit = 1'b0;
              for (int j = 0; j < ND; j++)
                if (j != k && dig(v, k) == dig(tgt, j)) hit = 1'b1;
              if (hit) m_cows++;
            end
          end
          m_st = RESULT;
          lat = 2 * ND + 1;
        end
      end
      RESULT: begin
        if (m_bulls == ND) begin
          m_st = WIN; m_win = m_pl;
        end else if (!m_pl) begin
          m_st = P2_GUESS; m_pl = 1'b1;
        end else if (m_round == MR) begin
          m_st = DRAW;
        end else begin
          m_round++; m_st = P1_GUESS; m_pl = 1'b0;
        end
      end
      default: m_reset();
    endcase
    expq.push_back(snap_model(lat));
    sw = v;
    confirma = 1'b1;
    @(posedge clock); #1;
    confirma = 1'b0;
    sw = SW'($urandom);
    wait_idle();
  endtask

  task automatic reset_dut(input logic hold);
    reset_n = 1'b0;
    confirma = hold;
    repeat (2) begin @(posedge clock); #1; end
    reset_n = 1'b1;
    m_reset();
  endtask

  initial begin
    logic [SW-1:0] v;
    logic done;
    int guard;
    m_reset();
    @(posedge clock); #1;

    // Reset with the button held: no transition until a fresh press.
    reset_dut(1'b1);
    snapshot();
    repeat (3) begin @(posedge clock); #1; end
    snapshot();
    confirma = 1'b0;
    @(posedge clock); #1;

    // Directed game: rejected setup, scoring 2/2, P2 wins.
    press(16'h1123);
    press(16'h1234);
    press(16'h5678);
    press(16'h5687);
    press(16'h0000);
    press(16'h1234);
    press(16'h0000);
    press(16'h0000);

    // Draw after MAX_ROUNDS with no hits.
    press(16'h1234);
    press(16'h5678);
    for (int r = 0; r < 2 * MR; r++) begin
      press(16'h9ABC);
      press(16'h0000);
    end
    snapshot();
    press(16'h0000);

    // Non-decimal digit entry, then reset in the middle of scoring.
    press(16'h12A4);
    press(16'h5678);
    sw = 16'h5687;
    confirma = 1'b1;
    @(posedge clock); #1;
    confirma = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    reset_dut(1'b0);
    snapshot();

    // Randomized games.
    for (int g = 0; g < 25; g++) begin
      done = 1'b0;
      guard = 0;
      while (!done && guard < 60) begin
        if ((m_st == P1_GUESS || m_st == P2_GUESS) && $urandom_range(0, 9) < 3)
          v = m_pl ? m_sec1 : m_sec2;
        else
          v = rand_entry();
        done = (m_st == WIN || m_st == DRAW);
        press(v);
        guard++;
      end
    end

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bc_game_engine.md
# bc_game_engine

Parametrised two-player Bulls & Cows game engine for the Nexys A7 top level. It supports any digit count and digit width, validates entries serially, and scores guesses serially. It tracks rounds with a draw limit and reports which player won. Display and LED decoding sit outside this block; it exports only status, scores and counters.

## Interface
Parameters:
- NUM_DIGITS, 4, digits per secret/guess (2..8)
- DIGIT_W, 4, bits per digit
- MAX_ROUNDS, 10, rounds before a draw (1..255)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- confirma  in  1  debounced confirm button, level
- sw  in  NUM_DIGITS*DIGIT_W  entry; digit k = sw[k*DIGIT_W +: DIGIT_W]
- state_o  out  4  current bc_state_t
- player_o  out  1  active player (0 = P1, 1 = P2)
- bulls_o  out  $clog2(NUM_DIGITS+1)  bulls of last scored guess
- cows_o  out  $clog2(NUM_DIGITS+1)  cows of last scored guess
- round_o  out  8  current round, 1-based
- err_o  out  1  last entry rejected
- winner_o  out  1  winning player; valid in WIN
- busy_o  out  1  high in VALIDATE/SCORE

## Operation
- Confirm edge: `conf_q <= confirma`; `edge = confirma & ~conf_q`. Edges are ignored in VALIDATE and SCORE.
- States: P1_SETUP, P2_SETUP, P1_GUESS, P2_GUESS, VALIDATE, SCORE, RESULT, WIN, DRAW.
- Setup/guess states, on edge:
  - `entry <= sw`
  - `ret <= current state`
  - `err_o <= 0`
  - next state VALIDATE, `idx <= 0`
- VALIDATE, one digit per cycle:
  - Digit idx fails if it equals any other entry digit.
  - After the last digit, on any failure: `err_o <= 1`, return to `ret`.
  - On success:
    - P1_SETUP -> store secret1, go to P2_SETUP.
    - P2_SETUP -> store secret2, go to P1_GUESS with `round = 1`.
    - From a guess state -> SCORE.
- SCORE:
  - Bulls and cows are cleared on entry.
  - Cycle k handles guess digit k: if it equals opponent-secret digit k, bulls+1; else if it equals any other opponent-secret digit, cows+1.
  - P1 guesses secret2; P2 guesses secret1.
  - After NUM_DIGITS cycles -> RESULT.
- RESULT holds bulls and cows. On edge:
  - If bulls == NUM_DIGITS -> WIN, `winner_o <= player`.
  - Else if P1 is active -> P2_GUESS.
  - Else if round == MAX_ROUNDS -> DRAW.
  - Else round+1 and go to P1_GUESS.
- First exact guess wins; P2 gets no equalising turn.
- WIN/DRAW: on edge -> P1_SETUP. Secrets, scores, round, err and winner are cleared.
- player_o: 0 in P1_* states, 1 in P2_* states. It holds its value through VALIDATE, SCORE and RESULT.

## Timing
- Reset (reset_n low at a clock edge):
  - state P1_SETUP; all outputs 0
  - `conf_q <= 1`, so a button held through reset produces no edge
  - secrets cleared
- Reset mid-VALIDATE or mid-SCORE aborts immediately; no partial results are retained.
- Edge to VALIDATE entry: 1 cycle after the edge cycle.
- VALIDATE lasts NUM_DIGITS cycles; SCORE lasts NUM_DIGITS cycles.
- Guess edge to RESULT: 2*NUM_DIGITS+1 cycles.
- Changes to sw after the edge have no effect; entry is captured.
- bulls + cows never exceeds NUM_DIGITS; the counters are sized so they cannot wrap.
- Round counter saturates at MAX_ROUNDS.

## Configuration
- BC_DECIMAL_ONLY_EN:
  - Defined: VALIDATE also rejects any digit > 9 (err_o = 1).
  - Undefined: every value 0..2^DIGIT_W-1 is legal.
  - Uniqueness checking is unchanged either way.

## Structure
- bc_pkg holds:
  - bc_state_t enum (4-bit, values in the listed order, P1_SETUP = 0)
  - BC_MAX_DECIMAL = 9
  - helper function for the score width
- Sub-module bc_digit_match is combinational:
  - Inputs: one digit, a vector, a position.
  - Outputs: pos_hit and other_hit.
  - Shared by VALIDATE (entry vs entry) and SCORE (guess vs secret).

## Test plan
- Reset with confirma held high, release reset -> state_o = P1_SETUP, no transition until confirma falls and rises again.
- P1 enters 16'h1123 -> err_o = 1, state_o returns to P1_SETUP. Then 16'h1234 -> err_o = 0, state_o = P2_SETUP.
- Secrets 16'h1234 / 16'h5678; P1 guesses 16'h5687 -> RESULT with bulls_o = 2, cows_o = 2, exactly 9 cycles after the edge.
- P2 guesses 16'h1234 -> bulls_o = 4, then edge -> WIN, winner_o = 1. Further edge -> P1_SETUP, round_o = 0.
- MAX_ROUNDS = 2, all guesses 16'h9ABC with no hits -> after P2's second RESULT, edge -> DRAW, round_o = 2.
- With BC_DECIMAL_ONLY_EN: 16'h12A4 -> err_o = 1. Without it: accepted. Separately, reset_n pulsed mid-SCORE -> P1_SETUP with bulls_o = cows_o = 0.
